ysyx_23060061_idu_pipe: RTL

Pipelined instruction decode stage for the next-generation NPC. It sits between IFU and EXU and uses valid/ready handshakes on both sides. Each cycle it decodes one RV32I instruction, plus RV32M when enabled, into a registered control and immediate bundle. It contains a 2-entry skid buffer, so the input-side ready never depends combinationally on the output-side ready. Branch resolution moves to EXU: this block emits a branch type and no longer consumes comparator results.

---
 rtl/ysyx_23060061_idu_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_idu_pipe.sv
// Pipelined RV32I(+M) decode stage between IFU and EXU.
// Decodes the instruction presented on the input handshake and captures the
// bundle into a 2-entry skid buffer (main + skid). Outputs come only from the
// main register, so they stay stable while the EXU stalls. in_ready is a
// registered function of the occupancy, so out_ready never reaches in_ready
// combinationally.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high (acc = in_valid & in_ready, pop = out_valid & out_ready). A producer
// holding valid keeps its payload stable until the transfer. valid never
// depends on ready.
module ysyx_23060061_idu_pipe #(
    parameter int XLEN      = 32,
    parameter int EN_M      = 0,
    parameter int EN_EBREAK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_write,
    output logic [1:0]      out_mem_rw,
    output logic [2:0]      out_mem_ext,
    output logic [3:0]      out_wmask,
    output logic            out_alu_a_sel,
    output logic            out_alu_b_sel,
    output logic [1:0]      out_wb_sel,
    output logic [4:0]      out_alu_op,
    output logic            out_branch,
    output logic [2:0]      out_br_type,
    output logic            out_jump,
    output logic            out_ebreak,
    output logic            out_illegal,
    output logic [1:0]      dbgState
);

    if (XLEN != 32) begin : gXlenCheck
        $error("ysyx_23060061_idu_pipe: only XLEN=32 is supported");
    end

    // Opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_PASSB  = 5'd2;
    localparam logic [4:0] ALU_ADDCLR = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_SLT    = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SRL    = 5'd8;
    localparam logic [4:0] ALU_SLL    = 5'd9;
    localparam logic [4:0] ALU_OR     = 5'd10;
    localparam logic [4:0] ALU_AND    = 5'd11;
    localparam logic [4:0] ALU_MUL    = 5'd16;

    // Writeback source
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            regWrite;
        logic [1:0]      memRw;
        logic [2:0]      memExt;
        logic [3:0]      wmask;
        logic            aluASel;
        logic            aluBSel;
        logic [1:0]      wbSel;
        logic [4:0]      aluOp;
        logic            branch;
        logic [2:0]      brType;
        logic            jump;
        logic            ebreak;
        logic            illegal;
    } Bundle;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } OccState;

    OccState stateQ, stateNext;
    logic    inReadyQ;
    Bundle   mainQ, skidQ, dec;
    logic    loadMain, loadSkid, moveSkid;
    logic    acc, pop;

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1F, rs2F, rdF;
    logic [31:0] immI, immS, immB, immU, immJ;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rs1F   = in_inst[19:15];
    assign rs2F   = in_inst[24:20];
    assign rdF    = in_inst[11:7];
    assign immI   = {{20{in_inst[31]}}, in_inst[31:20]};
    assign immS   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign immB   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign immU   = {in_inst[31:12], 12'b0};
    assign immJ   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // ALU op shared by OP-IMM and OP for the funct7=0 encodings
    function automatic logic [4:0] baseOp(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Combinational decode of in_inst; an unrecognised encoding collapses to a
    // bundle carrying only the PC and the illegal flag.
    always_comb begin
        logic legal;
        logic usesRd;
        dec    = '0;
        legal  = 1'b0;
        usesRd = 1'b0;
        dec.pc = in_pc;
        case (opcode)
            OP_LUI: begin
                legal       = 1'b1;
                usesRd      = 1'b1;
                dec.rd      = rdF;
                dec.imm     = immU;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_PASSB;
                dec.wbSel   = WB_ALU;
            end
            OP_AUIPC: begin
                legal       = 1'b1;
                usesRd      = 1'b1;
                dec.rd      = rdF;
                dec.imm     = immU;
                dec.aluASel = 1'b1;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADD;
                dec.wbSel   = WB_ALU;
            end
            OP_JAL: begin
                legal       = 1'b1;
                usesRd      = 1'b1;
                dec.rd      = rdF;
                dec.imm     = immJ;
                dec.aluASel = 1'b1;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADD;
                dec.wbSel   = WB_PC4;
                dec.jump    = 1'b1;
            end
            OP_JALR: begin
                legal       = (funct3 == 3'b000);
                usesRd      = 1'b1;
                dec.rs1     = rs1F;
                dec.rd      = rdF;
                dec.imm     = immI;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADDCLR;
                dec.wbSel   = WB_PC4;
                dec.jump    = 1'b1;
            end
            OP_BRANCH: begin
                legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.rs1     = rs1F;
                dec.rs2     = rs2F;
                dec.imm     = immB;
                dec.aluASel = 1'b1;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADD;
                dec.branch  = 1'b1;
                dec.brType  = funct3;
            end
            OP_LOAD: begin
                legal       = 1'b1;
                usesRd      = 1'b1;
                dec.rs1     = rs1F;
                dec.rd      = rdF;
                dec.imm     = immI;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADD;
                dec.memRw   = 2'b10;
                dec.wbSel   = WB_MEM;
                case (funct3)
                    3'b000:  dec.memExt = 3'b001;
                    3'b001:  dec.memExt = 3'b010;
                    3'b010:  dec.memExt = 3'b000;
                    3'b100:  dec.memExt = 3'b011;
                    3'b101:  dec.memExt = 3'b100;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                legal       = 1'b1;
                dec.rs1     = rs1F;
                dec.rs2     = rs2F;
                dec.imm     = immS;
                dec.aluBSel = 1'b1;
                dec.aluOp   = ALU_ADD;
                dec.memRw   = 2'b01;
                case (funct3)
                    3'b000:  dec.wmask = 4'b0001;
                    3'b001:  dec.wmask = 4'b0011;
                    3'b010:  dec.wmask = 4'b1111;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                usesRd      = 1'b1;
                dec.rs1     = rs1F;
                dec.rd      = rdF;
                dec.imm     = immI;
                dec.aluBSel = 1'b1;
                dec.wbSel   = WB_ALU;
                dec.aluOp   = baseOp(funct3);
                if (funct3 == 3'b001) begin
                    legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    if (funct7 == F7_ALT) dec.aluOp = ALU_SRA;
                end else begin
                    legal = 1'b1;
                end
            end
            OP_REG: begin
                usesRd    = 1'b1;
                dec.rs1   = rs1F;
                dec.rs2   = rs2F;
                dec.rd    = rdF;
                dec.wbSel = WB_ALU;
                dec.aluOp = baseOp(funct3);
                if (funct7 == F7_ZERO) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        legal     = 1'b1;
                        dec.aluOp = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        legal     = 1'b1;
                        dec.aluOp = ALU_SRA;
                    end
                end else if (funct7 == F7_MUL) begin
                    legal     = (EN_M != 0);
                    dec.aluOp = ALU_MUL | {2'b00, funct3};
                end
            end
            OP_SYSTEM: begin
                if ((in_inst == 32'h0010_0073) && (EN_EBREAK != 0)) begin
                    legal      = 1'b1;
                    dec.ebreak = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase
        dec.regWrite = usesRd && (rdF != 5'd0);
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign acc = in_valid && inReadyQ;
    assign pop = out_valid && out_ready;

    // Occupancy next-state and buffer load controls; flush wins over everything
    always_comb begin
        stateNext = stateQ;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (stateQ)
                EMPTY: begin
                    if (acc) begin
                        stateNext = ONE;
                        loadMain  = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        stateNext = TWO;
                        loadSkid  = 1'b1;
                    end else if (acc && pop) begin
                        loadMain  = 1'b1;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        stateNext = ONE;
                        moveSkid  = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Occupancy state and registered input-side ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= EMPTY;
            inReadyQ <= 1'b0;
        end else begin
            stateQ   <= stateNext;
            inReadyQ <= (stateNext != TWO);
        end
    end

    // Main and skid payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            if (loadMain) begin
                mainQ <= dec;
            end else if (moveSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkid) begin
                skidQ <= dec;
            end
        end
    end

    assign in_ready      = inReadyQ;
    assign out_valid     = (stateQ != EMPTY);
    assign dbgState      = stateQ;
    assign out_pc        = mainQ.pc;
    assign out_rs1       = mainQ.rs1;
    assign out_rs2       = mainQ.rs2;
    assign out_rd        = mainQ.rd;
    assign out_imm       = mainQ.imm;
    assign out_reg_write = mainQ.regWrite;
    assign out_mem_rw    = mainQ.memRw;
    assign out_mem_ext   = mainQ.memExt;
    assign out_wmask     = mainQ.wmask;
    assign out_alu_a_sel = mainQ.aluASel;
    assign out_alu_b_sel = mainQ.aluBSel;
    assign out_wb_sel    = mainQ.wbSel;
    assign out_alu_op    = mainQ.aluOp;
    assign out_branch    = mainQ.branch;
    assign out_br_type   = mainQ.brType;
    assign out_jump      = mainQ.jump;
    assign out_ebreak    = mainQ.ebreak;
    assign out_illegal   = mainQ.illegal;

endmodule
